// File: rtl/rt_32b_dcnt_pkg.sv
// Shared constants and state encoding for the 32-bit down-counting timer.
package rt_cnt_pkg;
  localparam int SEG_W = 8;
  localparam int NSEG  = 4;
  localparam int CNT_W = SEG_W * NSEG;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } rt_dcnt_st_e;
endpackage

// File: rtl/rt_32b_dcnt_if.sv
// Load handshake, control and status bundle of the down-counting timer.
interface rt_32b_dcnt_if #(parameter int CNT_W = rt_cnt_pkg::CNT_W);
  logic             rt_i_ce;
  logic             rt_i_load_vld;
  logic             rt_o_load_rdy;
  logic [CNT_W-1:0] rt_i_load_val;
  logic             rt_i_auto;
  logic             rt_i_stop;
  logic [CNT_W-1:0] rt_o_cnt;
  logic             rt_o_busy;
  logic             rt_o_expire;

  modport master (
    output rt_i_ce, rt_i_load_vld, rt_i_load_val, rt_i_auto, rt_i_stop,
    input  rt_o_load_rdy, rt_o_cnt, rt_o_busy, rt_o_expire
  );

  modport slave (
    input  rt_i_ce, rt_i_load_vld, rt_i_load_val, rt_i_auto, rt_i_stop,
    output rt_o_load_rdy, rt_o_cnt, rt_o_busy, rt_o_expire
  );
endinterface

// File: rtl/rt_32b_dcnt_seg.sv
// One down-counting segment; wraps 0 -> all-ones when it borrows.
module rt_dcnt_seg #(
  parameter int SEG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [SEG_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [SEG_W-1:0] o_val,
  output logic             o_zero
);
  logic [SEG_W-1:0] r_val;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_val <= '0;
    else if (i_load) r_val <= i_load_val;
    else if (i_dec)  r_val <= r_val - SEG_W'(1);
  end

  assign o_val  = r_val;
  assign o_zero = (r_val == '0);
endmodule

// File: rtl/rt_32b_dcnt.sv
// Loadable down-counting timer: segment cascade, IDLE/RUN control, reload and expire.
module rt_32b_dcnt #(
  parameter int SEG_W = 8,
  parameter int NSEG  = 4
) (
  input logic         rt_i_clk,
  input logic         rt_i_rst_n,
  rt_32b_dcnt_if.slave bus
);
  import rt_cnt_pkg::rt_dcnt_st_e;
  import rt_cnt_pkg::IDLE;
  import rt_cnt_pkg::RUN;

  localparam int CNT_W = SEG_W * NSEG;

  rt_dcnt_st_e      r_state;
  logic [CNT_W-1:0] r_reload;
  logic             r_auto;
  logic             r_expire;

  logic [NSEG-1:0]  w_zero;
  logic [NSEG-1:0]  w_dec_en;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_ld_val;
  logic             w_idle, w_run, w_tick, w_all_zero;
  logic             w_accept, w_term, w_dec, w_seg_load;

  assign w_idle     = (r_state == IDLE);
  assign w_run      = (r_state == RUN);
  assign w_all_zero = &w_zero;
  assign w_accept   = w_idle & bus.rt_i_load_vld & rt_i_rst_n;
  // stop outranks a terminal tick, so it is folded into the tick itself
  assign w_tick     = w_run & bus.rt_i_ce & ~bus.rt_i_stop;
  assign w_term     = w_tick & w_all_zero;
  assign w_dec      = w_tick & ~w_all_zero;
  assign w_seg_load = w_accept | (w_term & r_auto);
  assign w_ld_val   = w_idle ? bus.rt_i_load_val : r_reload;

  // each segment borrows only when every lower segment is already zero
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    if (k == 0) begin : g_lsb
      assign w_dec_en[k] = w_dec;
    end else begin : g_upper
      assign w_dec_en[k] = w_dec & (&w_zero[k-1:0]);
    end

    rt_dcnt_seg #(.SEG_W(SEG_W)) u_seg (
      .i_clk      (rt_i_clk),
      .i_rst_n    (rt_i_rst_n),
      .i_load     (w_seg_load),
      .i_load_val (w_ld_val[k*SEG_W +: SEG_W]),
      .i_dec      (w_dec_en[k]),
      .o_val      (w_cnt[k*SEG_W +: SEG_W]),
      .o_zero     (w_zero[k])
    );
  end

  always_ff @(posedge rt_i_clk) begin
    if (!rt_i_rst_n) begin
      r_state  <= IDLE;
      r_reload <= '0;
      r_auto   <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_expire <= w_term;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= RUN;
            r_reload <= bus.rt_i_load_val;
            r_auto   <= bus.rt_i_auto;
          end
        end
        RUN: begin
          if (bus.rt_i_stop)          r_state <= IDLE;
          else if (w_term && !r_auto) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rt_o_load_rdy = w_idle & rt_i_rst_n;
  assign bus.rt_o_busy     = w_run;
  assign bus.rt_o_cnt      = w_cnt;
  assign bus.rt_o_expire   = r_expire;
endmodule

// File: doc/rt_32b_dcnt.md
# rt_32b_dcnt

Loadable 32-bit down-counting timer, the countdown counterpart to the team's free-running 32-bit up-counter. It is built from four cascaded 8-bit down segments with ripple-free borrow enables, and counts `rt_i_ce` ticks from a loaded value to zero. At zero it emits a one-cycle expire pulse, then either stops (one-shot) or reloads (auto-reload). It sits beside the up-counter in the timing subsystem and drives timeouts and periodic events.

## Interface
- `SEG_W`, default 8: width of one counter segment.
- `NSEG`, default 4: number of segments; total width is SEG_W*NSEG = 32.
- `rt_i_clk` in, 1: clock.
- `rt_i_rst_n` in, 1: synchronous, active-low reset.
- `rt_i_ce` in, 1: count-enable tick; one decrement per cycle it is high in RUN.
- `rt_i_load_vld` in, 1: load request.
- `rt_o_load_rdy` out, 1: load can be accepted.
- `rt_i_load_val` in, 32: start value, sampled on the accept edge.
- `rt_i_auto` in, 1: auto-reload mode, sampled on the accept edge.
- `rt_i_stop` in, 1: abort countdown.
- `rt_o_cnt` out, 32: current count, `{seg3,seg2,seg1,seg0}`.
- `rt_o_busy` out, 1: high in RUN.
- `rt_o_expire` out, 1: one-cycle terminal pulse.

One clock; reset is synchronous and active-low.

## Operation
- **Reset** (`rt_i_rst_n`=0 at an edge):
  - state IDLE, all segments 0, reload register 0, auto flag 0.
  - `rt_o_expire`=0, `rt_o_busy`=0.
  - `rt_o_load_rdy`=0 while reset is low; load requests during reset are ignored.
- **States:** IDLE and RUN.
  - `rt_o_load_rdy` = (state==IDLE) & `rt_i_rst_n`.
  - `rt_o_busy` = (state==RUN).
- **IDLE:** on `rt_i_load_vld & rt_o_load_rdy`:
  - count and reload register ← `rt_i_load_val`; auto flag ← `rt_i_auto`; state → RUN.
  - `rt_i_ce` and `rt_i_stop` are ignored in IDLE; count holds.
- **RUN, `rt_i_ce`=1, count≠0:** decrement by 1 via the segment cascade.
  - Segment 0 decrements on ce.
  - Segment k decrements on ce & (segments 0..k-1 all zero); it wraps 0→0xFF when borrowing.
- **RUN, `rt_i_ce`=1, count==0 (terminal):** expire pulse.
  - auto=1: count ← reload register, stay in RUN.
  - auto=0: count stays 0, state → IDLE.
- **Countdown length:** loading N gives expire on the (N+1)th ce after the load, which is the period N+1 in auto mode. Loading 0 expires on the first ce.
- **RUN, `rt_i_stop`=1:** state → IDLE, count holds its current value, no expire.
  - Stop wins over a simultaneous terminal ce: no expire, no reload.
- **Loads in RUN** are refused (`rt_o_load_rdy`=0). Software stops the timer first.
- **Reset mid-RUN:** immediate return to reset values; a pending expire is discarded.
- **Arithmetic:** unsigned, modulo 2^32. The load value 0xFFFFFFFF is legal and needs 2^32 ticks.

## Timing
- Load accepted at edge T: `rt_o_cnt`=N and `rt_o_busy`=1 in cycle T+1. The earliest decrement is at edge T+1.
- Decrement is visible one cycle after the ce edge. All segment carries resolve in that same cycle; there is no multi-cycle ripple.
- `rt_o_expire` is registered. It is high for exactly the one cycle following the terminal-ce edge, coincident with the reload value or the IDLE state.
- Back-to-back: in auto mode with ce held high, `rt_o_expire` pulses every N+1 cycles. For N=0 it stays high every cycle.
- After a one-shot expire, `rt_o_load_rdy`=1 in the same cycle that `rt_o_expire`=1, so a new load can be accepted at that edge.
- All outputs are registered except `rt_o_load_rdy` and `rt_o_busy`, which are decoded from the state register.

## Structure
- Package `rt_cnt_pkg` holds:
  - `SEG_W`, `NSEG` and `CNT_W` constants;
  - the state enum `rt_dcnt_st_e` {IDLE, RUN}.
- Sub-module `rt_dcnt_seg`: one SEG_W down segment.
  - Inputs: load, load value, dec enable.
  - Outputs: value, zero flag.
  - Instantiated NSEG times.
- The top level holds the FSM, the reload register, the borrow-enable AND chain and the expire register.

## Test plan
- **Reset then one-shot:** load 3 with auto=0, ce held high.
  - `rt_o_cnt` goes 3,2,1,0.
  - `rt_o_expire` is high exactly once, the cycle after the 4th ce.
  - Then IDLE, `rt_o_busy`=0, `rt_o_cnt`=0.
- **Segment borrow:** load 0x01000000, one ce → `rt_o_cnt`=0x00FFFFFF after one cycle.
- **Auto-reload:**
  - load 2 with auto=1, ce high for 9 cycles → expire pulses on the cycles after ce #3, #6 and #9; count returns to 2 after each.
  - load 0 with auto=1 → expire high every cycle.
- **Stop vs terminal:** load 0 with auto=0, assert ce and stop on the same cycle → no expire, state IDLE, count 0.
  - Stop at count 5 → count holds 5, IDLE.
- **Handshake:**
  - load_vld in RUN → refused, count unaffected.
  - load_vld held during reset → no load.
  - load issued in the expire cycle → accepted.
- **Gapped ce and reset mid-run:**
  - ce toggling 1,0,1 from count 10 → 8 after three cycles.
  - reset at count 8 → count 0, busy 0, no expire.
